// File: rtl/mult_stream_adapter.sv
// mult_stream_adapter
//   Sequential wrapper around a combinational 64x64 multiplier. Collects two
//   64-bit operands as four 32-bit input beats, holds them on the multiplier
//   inputs for SETTLE_CYCLES cycles, captures the 128-bit product and returns
//   it as four 32-bit output beats, least-significant word first.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     : input beat handshake, payload s_data[31:0]
//   m_valid/m_ready     : output beat handshake, payload m_data[31:0]
//   m_last              : marks the fourth (final) output beat
//   mult_in1, mult_in2  : operands driven to the multiplier IN1/IN2
//   mult_out            : product from the multiplier OUTPUT
//   busy                : high whenever the adapter is not in LOAD
module mult_stream_adapter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic [63:0]  mult_in1,
  output logic [63:0]  mult_in2,
  input  logic [127:0] mult_out,
  output logic         busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mult_stream_adapter: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    SEND
  } state_e;

  state_e         state_q,   state_d;
  logic [1:0]     beat_q,    beat_d;
  logic [7:0]     cnt_q,     cnt_d;
  logic [63:0]    in1_q,     in1_d;
  logic [63:0]    in2_q,     in2_d;
  logic [127:0]   res_q,     res_d;
  logic           s_ready_q, s_ready_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q,  m_last_d;
  logic           busy_q,    busy_d;

  logic s_hs;
  logic m_hs;

  assign s_hs = s_valid && s_ready_q;
  assign m_hs = m_valid_q && m_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;

    unique case (state_q)
      LOAD: begin
        if (s_hs) begin
          unique case (beat_q)
            2'd0: in1_d[31:0]  = s_data;
            2'd1: in1_d[63:32] = s_data;
            2'd2: in2_d[31:0]  = s_data;
            2'd3: in2_d[63:32] = s_data;
          endcase
          // Index wraps to 0 on beat 3, ready for the output phase.
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          res_d   = mult_out;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_hs) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        beat_d  = '0;
      end
    endcase

    // Handshake flags are registered: derive them from the next state so
    // they line up with the state register on the same edge.
    s_ready_d = (state_d == LOAD);
    m_valid_d = (state_d == SEND);
    m_last_d  = (state_d == SEND) && (beat_d == 2'd3);
    busy_d    = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      beat_q    <= '0;
      cnt_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      res_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      res_q     <= res_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    m_data = '0;
    unique case (beat_q)
      2'd0: m_data = res_q[31:0];
      2'd1: m_data = res_q[63:32];
      2'd2: m_data = res_q[95:64];
      2'd3: m_data = res_q[127:96];
    endcase
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign busy     = busy_q;
  assign mult_in1 = in1_q;
  assign mult_in2 = in2_q;

endmodule

// File: tb/tb_mult_stream_adapter.sv
// Directed testbench for mult_stream_adapter with a behavioural multiplier.
module tb_mult_stream_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic [63:0]  mult_in1;
  logic [63:0]  mult_in2;
  logic [127:0] mult_out;
  logic         busy;

  logic xmode;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   h;
  int   n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural multiplier; drives X while the product is "still resolving".
  assign mult_out = xmode ? 128'bx : ({64'b0, mult_in1} * {64'b0, mult_in2});

  mult_stream_adapter #(.SETTLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .mult_in1 (mult_in1),
    .mult_in2 (mult_in2),
    .mult_out (mult_out),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic send_beat(input logic [31:0] d, input int gap);
    int k;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    k = 0;
    while (!s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("s_ready_wait", {63'b0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic recv_beat(input logic [31:0] d, input logic last, input string tag);
    int k;
    m_ready = 1'b1;
    k = 0;
    while (!m_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {63'b0, m_valid}, 64'd1);
    check({tag, "_data"},  {32'b0, m_data},  {32'b0, d});
    check({tag, "_last"},  {63'b0, m_last},  {63'b0, last});
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    xmode   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", {63'b0, s_ready}, 64'd0);
    check("rst_m_valid", {63'b0, m_valid}, 64'd0);
    check("rst_m_last",  {63'b0, m_last},  64'd0);
    check("rst_busy",    {63'b0, busy},    64'd0);
    check("rst_in1",     mult_in1,         64'd0);
    check("rst_in2",     mult_in2,         64'd0);
    check("rst_m_data",  {32'b0, m_data},  64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready_0", {63'b0, s_ready}, 64'd0);
    @(negedge clk);
    check("rel_s_ready_1", {63'b0, s_ready}, 64'd1);
    check("rel_busy",      {63'b0, busy},    64'd0);

    // All-ones operands with latency and X-until-settled multiplier
    send_beat(32'hFFFFFFFF, 0);
    send_beat(32'hFFFFFFFF, 0);
    send_beat(32'hFFFFFFFF, 0);
    xmode = 1'b1;
    send_beat(32'hFFFFFFFF, 0);
    h = cyc;
    check("ones_busy",    {63'b0, busy},    64'd1);
    check("ones_s_ready", {63'b0, s_ready}, 64'd0);
    n = 0;
    while (!m_valid && n < 20) begin
      if (cyc - h >= 3) xmode = 1'b0;
      @(negedge clk);
      n++;
    end
    xmode = 1'b0;
    check("latency", 64'(cyc - h), 64'd4);
    check("ones_in1", mult_in1, 64'hFFFFFFFFFFFFFFFF);
    check("ones_in2", mult_in2, 64'hFFFFFFFFFFFFFFFF);
    recv_beat(32'h00000001, 1'b0, "ones_b0");
    recv_beat(32'h00000000, 1'b0, "ones_b1");
    recv_beat(32'hFFFFFFFE, 1'b0, "ones_b2");
    recv_beat(32'hFFFFFFFF, 1'b1, "ones_b3");
    m_ready = 1'b0;
    check("ones_end_s_ready", {63'b0, s_ready}, 64'd1);
    check("ones_end_m_valid", {63'b0, m_valid}, 64'd0);
    check("ones_end_busy",    {63'b0, busy},    64'd0);

    // Gapped input, ignored s_valid while busy, backpressure on beat 1
    send_beat(32'h9ABCDEF0, $urandom_range(0, 3));
    send_beat(32'h12345678, $urandom_range(0, 3));
    send_beat(32'h00000002, $urandom_range(0, 3));
    send_beat(32'h00000000, $urandom_range(0, 3));
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("gap_in1_frozen", mult_in1, 64'h123456789ABCDEF0);
    check("gap_in2_frozen", mult_in2, 64'h0000000000000002);
    check("gap_s_ready",    {63'b0, s_ready}, 64'd0);
    s_valid = 1'b0;
    recv_beat(32'h3579BDE0, 1'b0, "gap_b0");
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_m_data",  {32'b0, m_data},  64'h2468ACF1);
      check("bp_m_valid", {63'b0, m_valid}, 64'd1);
      check("bp_m_last",  {63'b0, m_last},  64'd0);
      check("bp_s_ready", {63'b0, s_ready}, 64'd0);
      @(negedge clk);
    end
    recv_beat(32'h2468ACF1, 1'b0, "gap_b1");
    recv_beat(32'h00000000, 1'b0, "gap_b2");
    recv_beat(32'h00000000, 1'b1, "gap_b3");
    m_ready = 1'b0;

    // Reset after output beat 1 is accepted
    send_beat(32'h00000007, 0);
    send_beat(32'h00000000, 0);
    send_beat(32'h00000009, 0);
    send_beat(32'h00000000, 0);
    recv_beat(32'h0000003F, 1'b0, "ab_b0");
    recv_beat(32'h00000000, 1'b0, "ab_b1");
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("ab_m_valid", {63'b0, m_valid}, 64'd0);
    check("ab_busy",    {63'b0, busy},    64'd0);
    check("ab_s_ready", {63'b0, s_ready}, 64'd0);
    check("ab_m_data",  {32'b0, m_data},  64'd0);
    check("ab_in1",     mult_in1,         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_rel_s_ready", {63'b0, s_ready}, 64'd1);
    send_beat(32'h00000003, 0);
    send_beat(32'h00000000, 0);
    send_beat(32'h00000005, 0);
    send_beat(32'h00000000, 0);
    check("ab2_in1", mult_in1, 64'd3);
    check("ab2_in2", mult_in2, 64'd5);
    recv_beat(32'h0000000F, 1'b0, "ab2_b0");
    recv_beat(32'h00000000, 1'b0, "ab2_b1");
    recv_beat(32'h00000000, 1'b0, "ab2_b2");
    recv_beat(32'h00000000, 1'b1, "ab2_b3");
    m_ready = 1'b0;
    check("ab2_end_s_ready", {63'b0, s_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
